// File: rtl/hazard_stall_ctrl.sv
// Hazard detection / stall controller for a 5-stage in-order pipeline.
// Optional build macro HAZARD_FORWARDING_EN: only load-use hazards stall.
module hazard_stall_ctrl #(
    parameter int                   OP_W       = 4,
    parameter int                   REG_W      = 4,
    parameter logic [2**OP_W-1:0]   READS_MASK = 16'h000F,
    parameter logic [OP_W-1:0]      LOAD_OP    = 4'b0100,
    parameter int                   IGNORE_R0  = 1,
    parameter int                   CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OP_W-1:0]  IF_ID_opcode,
    input  logic [REG_W-1:0] IF_ID_op1,
    input  logic [REG_W-1:0] IF_ID_op2,
    input  logic [OP_W-1:0]  ID_EX_opcode,
    input  logic [REG_W-1:0] ID_EX_dest,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] EX_MEM_dest,
    input  logic             EX_MEM_RegWrite,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             IF_ID_Hold,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             hasHazard,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic [1:0]       r_rem;
    logic [CNT_W-1:0] r_cnt;

    logic       w_reads;
    logic       w_ex_hit;
    logic [1:0] w_need;
    logic       w_hz;
    logic       w_unused;

    assign w_reads  = READS_MASK[IF_ID_opcode];
    assign w_ex_hit = ID_EX_RegWrite && w_reads &&
                      (ID_EX_dest == IF_ID_op1 || ID_EX_dest == IF_ID_op2) &&
                      !(IGNORE_R0 != 0 && ID_EX_dest == '0);

`ifdef HAZARD_FORWARDING_EN
    assign w_need   = (w_ex_hit && ID_EX_opcode == LOAD_OP) ? 2'd1 : 2'd0;
    // MEM-stage inputs only matter without a forwarding path
    assign w_unused = ^{EX_MEM_dest, EX_MEM_RegWrite};
`else
    logic w_mem_hit;
    assign w_mem_hit = EX_MEM_RegWrite && w_reads &&
                       (EX_MEM_dest == IF_ID_op1 || EX_MEM_dest == IF_ID_op2) &&
                       !(IGNORE_R0 != 0 && EX_MEM_dest == '0);
    assign w_need    = w_ex_hit ? 2'd2 : (w_mem_hit ? 2'd1 : 2'd0);
    // producer opcode only matters when forwarding is present
    assign w_unused  = (ID_EX_opcode == LOAD_OP);
`endif

    // Outputs are combinational so a fresh hazard stalls with zero latency;
    // they are forced to the idle pattern while reset is held.
    always_comb begin
        pc_write     = 1'b1;
        IF_ID_Hold   = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        w_hz         = 1'b0;
        if (!reset) begin
            w_hz = 1'b0;
        end else if (branch_taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (r_state == STALL || w_need != 2'd0) begin
            w_hz         = 1'b1;
            pc_write     = 1'b0;
            IF_ID_Hold   = 1'b1;
            ID_EX_Bubble = 1'b1;
        end
    end

    assign hasHazard    = w_hz;
    assign stall_cycles = r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rem   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            if (w_hz && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_ONE;
            if (branch_taken) begin
                r_state <= IDLE;
                r_rem   <= 2'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_need == 2'd2) begin
                            r_state <= STALL;
                            r_rem   <= 2'd1;
                        end
                    end
                    STALL: begin
                        r_rem <= r_rem - 2'd1;
                        if (r_rem == 2'd1)
                            r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_rem   <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed bench for hazard_stall_ctrl with a cycle-level reference model.
// Honours HAZARD_FORWARDING_EN the same way the design does.
module tb_hazard_stall_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] IF_ID_opcode = '0, IF_ID_op1 = '0, IF_ID_op2 = '0;
    logic [3:0] ID_EX_opcode = '0, ID_EX_dest = '0, EX_MEM_dest = '0;
    logic       ID_EX_RegWrite = 1'b0, EX_MEM_RegWrite = 1'b0, branch_taken = 1'b0;

    logic        pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard;
    logic [15:0] stall_cycles;
    logic        s_pc, s_hold, s_flush, s_bub, s_hz;
    logic [1:0]  s_stall;

    always #5 clock = ~clock;

    hazard_stall_ctrl u_dut (
        .clock(clock), .reset(reset),
        .IF_ID_opcode(IF_ID_opcode), .IF_ID_op1(IF_ID_op1), .IF_ID_op2(IF_ID_op2),
        .ID_EX_opcode(ID_EX_opcode), .ID_EX_dest(ID_EX_dest), .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_dest(EX_MEM_dest), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .branch_taken(branch_taken),
        .pc_write(pc_write), .IF_ID_Hold(IF_ID_Hold), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .hasHazard(hasHazard), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.CNT_W(2)) u_sat (
        .clock(clock), .reset(reset),
        .IF_ID_opcode(IF_ID_opcode), .IF_ID_op1(IF_ID_op1), .IF_ID_op2(IF_ID_op2),
        .ID_EX_opcode(ID_EX_opcode), .ID_EX_dest(ID_EX_dest), .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_dest(EX_MEM_dest), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .branch_taken(branch_taken),
        .pc_write(s_pc), .IF_ID_Hold(s_hold), .IF_ID_Flush(s_flush),
        .ID_EX_Bubble(s_bub), .hasHazard(s_hz), .stall_cycles(s_stall)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Reference model: outstanding stall cycles and total stall count
    int         m_rem = 0;
    int         m_cnt = 0;
    logic [4:0] e_out;          // {pc_write, Hold, Flush, Bubble, hasHazard}
    int         e_cnt;
    int         e_sat;

    function automatic logic src_hit(input logic [3:0] d);
        logic [15:0] mask;
        mask = 16'h000F;
        return mask[IF_ID_opcode] && (d == IF_ID_op1 || d == IF_ID_op2) && (d != 4'd0);
    endfunction

    function automatic int need_fn();
`ifdef HAZARD_FORWARDING_EN
        return (ID_EX_RegWrite && src_hit(ID_EX_dest) && ID_EX_opcode == 4'b0100) ? 1 : 0;
`else
        if (ID_EX_RegWrite && src_hit(ID_EX_dest))   return 2;
        if (EX_MEM_RegWrite && src_hit(EX_MEM_dest)) return 1;
        return 0;
`endif
    endfunction

    task automatic predict();
        if (!reset) begin
            m_rem = 0;
            m_cnt = 0;
            e_out = 5'b10000;
        end else if (branch_taken) e_out = 5'b10110;
        else if (m_rem > 0 || need_fn() > 0) e_out = 5'b01011;
        else e_out = 5'b10000;
        e_cnt = m_cnt;
        e_sat = (m_cnt > 3) ? 3 : m_cnt;
    endtask

    task automatic advance();
        int nd;
        nd = need_fn();
        @(posedge clock);
        if (!reset) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            if (e_out[0]) m_cnt++;
            if (branch_taken) m_rem = 0;
            else if (m_rem > 0) m_rem--;
            else if (nd == 2) m_rem = 1;
        end
        $display("cyc %0d rst=%b br=%b opc=%h op=%h/%h ex=%h/%b mem=%h/%b out=%b cnt=%0d",
                 cyc, reset, branch_taken, IF_ID_opcode, IF_ID_op1, IF_ID_op2,
                 ID_EX_dest, ID_EX_RegWrite, EX_MEM_dest, EX_MEM_RegWrite, e_out, e_cnt);
        cyc++;
        #1;
    endtask

    task automatic drive(input logic [3:0] opc, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exo, input logic [3:0] exd, input logic exw,
                         input logic [3:0] memd, input logic memw, input logic br);
        IF_ID_opcode = opc; IF_ID_op1 = a; IF_ID_op2 = b;
        ID_EX_opcode = exo; ID_EX_dest = exd; ID_EX_RegWrite = exw;
        EX_MEM_dest = memd; EX_MEM_RegWrite = memw; branch_taken = br;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom);
            predict();
            #2;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== 5'b10000) begin
                n_fails++;
                $display("FAIL reset_outs got=%b want=10000", {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard});
            end
            if (i > 0) begin
                n_checks++;
                if (stall_cycles !== 16'd0) begin
                    n_fails++;
                    $display("FAIL reset_cnt got=%0d want=0", stall_cycles);
                end
            end
            advance();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        predict();
        #2;
        n_checks++;
        if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard, stall_cycles} !== {5'b10000, 16'd0}) begin
            n_fails++;
            $display("FAIL reset_release got=%b/%0d want=10000/0", {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, stall_cycles);
        end
        advance();
    endtask

    task automatic test_ex_hazard();
        int start, nhz;
        start = m_cnt; nhz = 0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(4'b0001, 3, 9, 4'b0001, 3, 1, 0, 0, 0);
                1:       drive(4'b0001, 3, 9, 4'b0000, 0, 0, 3, 1, 0);
                default: drive(4'b0001, 3, 9, 4'b0000, 0, 0, 0, 0, 0);
            endcase
            predict();
            #2;
            nhz += hasHazard;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== e_out || stall_cycles !== e_cnt[15:0]) begin
                n_fails++;
                $display("FAIL ex_hazard[%0d] got=%b/%0d want=%b/%0d", i, {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, stall_cycles, e_out, e_cnt);
            end
            advance();
        end
        n_checks++;
        if (nhz != 2 || int'(stall_cycles) - start != 2) begin
            n_fails++;
            $display("FAIL ex_hazard_len got=%0d/%0d want=2", nhz, int'(stall_cycles) - start);
        end
    endtask

    task automatic test_mem_hazard();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(4'b0000, 1, 5, 0, 0, 0, 5, 1, 0);
                1: drive(4'b0000, 1, 5, 0, 0, 0, 5, 0, 0);
                default: drive(4'b0000, 0, 0, 0, 0, 1, 0, 1, 0);
            endcase
            predict();
            #2;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== e_out || stall_cycles !== e_cnt[15:0]) begin
                n_fails++;
                $display("FAIL mem_hazard[%0d] got=%b/%0d want=%b/%0d", i, {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, stall_cycles, e_out, e_cnt);
            end
            advance();
        end
    endtask

    task automatic test_branch_stall();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(4'b0010, 6, 2, 4'b0001, 6, 1, 0, 0, 0);
                1: drive(4'b0010, 6, 2, 4'b0000, 0, 0, 6, 1, 1);
                default: drive(4'b0010, 6, 2, 4'b0000, 0, 0, 0, 0, 0);
            endcase
            predict();
            #2;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== e_out) begin
                n_fails++;
                $display("FAIL branch_stall[%0d] got=%b want=%b", i, {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, e_out);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0011, 7, 7, 4'b0001, 7, i == 0, 0, 0, 0);
            reset = (i != 1);
            predict();
            #2;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== e_out || stall_cycles !== e_cnt[15:0]) begin
                n_fails++;
                $display("FAIL reset_mid_stall[%0d] got=%b/%0d want=%b/%0d", i, {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, stall_cycles, e_out, e_cnt);
            end
            advance();
        end
    endtask

    task automatic test_nonreading_and_sat();
        for (int i = 0; i < 7; i++) begin
            if (i == 0) drive(4'b0111, 4, 4, 4'b0001, 4, 1, 4, 1, 0);
            else        drive(4'b0001, 2, 8, 4'b0001, 2, 1, 0, 0, 0);
            predict();
            #2;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== e_out || s_stall !== e_sat[1:0]) begin
                n_fails++;
                $display("FAIL nonread_sat[%0d] got=%b/%0d want=%b/%0d", i, {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, s_stall, e_out, e_sat);
            end
            advance();
        end
        predict();
        #2;
        n_checks++;
        if (s_stall !== 2'd3 || e_cnt < 5) begin
            n_fails++;
            $display("FAIL sat_hold got=%0d want=3 (stalls=%0d)", s_stall, e_cnt);
        end
        advance();
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(4'b0001, 9, 1, 4'b0001, 9, 1, 0, 0, 0);
                1: drive(4'b0001, 9, 1, 4'b0000, 0, 0, 9, 1, 0);
                2: drive(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
                3: drive(4'b0001, 1, 9, 4'b0100, 9, 1, 0, 0, 0);
                default: drive(4'b0001, 1, 9, 4'b0000, 0, 0, 9, 1, 0);
            endcase
            predict();
            #2;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== e_out || stall_cycles !== e_cnt[15:0]) begin
                n_fails++;
                $display("FAIL forwarding[%0d] got=%b/%0d want=%b/%0d", i, {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, stall_cycles, e_out, e_cnt);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0) ? 4'b0100 : 4'b0001, $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) != 0);
            predict();
            #2;
            n_checks++;
            if ({pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard} !== e_out ||
                stall_cycles !== e_cnt[15:0] || s_stall !== e_sat[1:0] || (IF_ID_Hold && IF_ID_Flush)) begin
                n_fails++;
                $display("FAIL random[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i, {pc_write, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, hasHazard}, stall_cycles, s_stall, e_out, e_cnt, e_sat);
            end
            advance();
        end
        reset = 1'b1;
    endtask

    initial begin
        #1;
        test_reset();
        test_ex_hazard();
        test_mem_hazard();
        test_branch_stall();
        test_reset_mid_stall();
        test_nonreading_and_sat();
        test_forwarding();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised hazard detection and stall controller for the in-order 5-stage pipeline (IF, ID, EX, MEM, WB). It sits beside the IF/ID and ID/EX pipeline registers.
- Compares the ID-stage source operands against valid, register-writing destinations in EX and MEM.
- A small FSM holds PC and IF/ID and inserts ID/EX bubbles for the required number of cycles.
- Also handles taken-branch flush priority and keeps a saturating count of stall cycles for performance.

Parameters:
- OP_W, 4, opcode width.
- REG_W, 4, register-index width.
- READS_MASK, 16'h000F, width 2**OP_W; bit k set means opcode k reads op1 and op2.
- LOAD_OP, 4'b0100, opcode of the memory-load instruction.
- IGNORE_R0, 1, when 1, register index 0 never causes a hazard.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- IF_ID_opcode  in  OP_W  opcode of the instruction in ID.
- IF_ID_op1  in  REG_W  source register 1 of the instruction in ID.
- IF_ID_op2  in  REG_W  source register 2 of the instruction in ID.
- ID_EX_opcode  in  OP_W  opcode of the instruction in EX.
- ID_EX_dest  in  REG_W  destination register of the instruction in EX.
- ID_EX_RegWrite  in  1  instruction in EX writes the register file.
- EX_MEM_dest  in  REG_W  destination register of the instruction in MEM.
- EX_MEM_RegWrite  in  1  instruction in MEM writes the register file.
- branch_taken  in  1  taken branch resolved this cycle.
- pc_write  out  1  1 = PC may advance.
- IF_ID_Hold  out  1  hold the IF/ID register.
- IF_ID_Flush  out  1  clear IF/ID to NOP.
- ID_EX_Bubble  out  1  load NOP (RegWrite=0) into ID/EX.
- hasHazard  out  1  a stall is being applied this cycle.
- stall_cycles  out  CNT_W  saturating count of stall cycles since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE and the remaining-stall counter goes to 0.
  - stall_cycles = 0, pc_write = 1; IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble and hasHazard = 0.
  - Reset mid-stall aborts the stall immediately.
- Read qualifier: reads = READS_MASK[IF_ID_opcode].
- Operand hit: hit_X(d) = reads && (d==IF_ID_op1 || d==IF_ID_op2) && !(IGNORE_R0 && d==0).
- Hits only count when the stage's RegWrite=1.
- Required bubbles, `need` (no forwarding; the register file writes in the first half-cycle, so the WB stage never hazards):
  - need=2 if the EX hit is valid.
  - else need=1 if the MEM hit is valid.
  - else need=0.
- FSM states:
  - IDLE:
    - need=0: pc_write=1, all other stall outputs 0.
    - need>=1: hasHazard=1, pc_write=0, IF_ID_Hold=1, ID_EX_Bubble=1 in the same cycle (combinational, zero latency).
    - need=2: next state STALL, rem=1.
    - need=1: stay IDLE.
  - STALL:
    - Outputs are as for a hazard; inputs are not re-evaluated.
    - rem decrements each cycle; when rem==1, next state is IDLE.
- branch_taken=1 in any state has priority:
  - IF_ID_Flush=1, ID_EX_Bubble=1, pc_write=1, IF_ID_Hold=0, hasHazard=0.
  - Next state IDLE, rem=0.
- IF_ID_Hold and IF_ID_Flush are never both 1.
- stall_cycles increments on every clock edge where hasHazard=1 and saturates at 2**CNT_W-1 (no wrap).

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined (a forwarding unit exists): ALU results are forwarded, so only load-use hazards stall.
  - need=1 iff the EX hit is valid and ID_EX_opcode==LOAD_OP; otherwise need=0.
  - MEM hits never stall; STALL is unreachable.
- Undefined: the need rules in Behaviour apply unchanged.

Test Plan:
- Reset:
  - Stimulus: reset=0 for 3 cycles with random inputs, then release.
  - Required: pc_write=1, all other outputs 0, stall_cycles=0 throughout.
- EX hazard:
  - Stimulus: IF_ID_opcode=0001, op1=3; ID_EX_dest=3, RegWrite=1; next cycle the bubble propagates (ID_EX_RegWrite=0, EX_MEM_dest=3).
  - Required: hasHazard=1 for exactly 2 cycles, then 0; stall_cycles=2.
- MEM-only hazard:
  - Stimulus: EX_MEM_dest=5, RegWrite=1, IF_ID_op2=5, opcode=0000.
  - Required: exactly 1 stall cycle; op1/op2=0 with dest=0 gives no stall.
- Branch during STALL:
  - Stimulus: branch_taken=1 in the 2nd stall cycle.
  - Required: that cycle IF_ID_Flush=1, pc_write=1, IF_ID_Hold=0; next cycle IDLE.
- Non-reading opcode and saturation:
  - Stimulus: IF_ID_opcode=0111 with a matching dest.
  - Required: no stall.
  - Stimulus: CNT_W=2 with 5 stall cycles.
  - Required: stall_cycles holds at 3.
- HAZARD_FORWARDING_EN defined:
  - Stimulus: ALU producer in EX.
  - Required: no stall.
  - Stimulus: ID_EX_opcode=LOAD_OP with a matching dest.
  - Required: exactly 1 stall cycle.
